// File: rtl/regfile_mp_if.sv
// Port bundle for regfile_mp: write ports, read ports, scoreboard issue and ready.
// Read and write ports are packed, with port i at [i*W +: W].
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
);
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     ready;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, issue_en, issue_addr,
    input  rd_data, rd_busy, ready
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, issue_en, issue_addr,
    output rd_data, rd_busy, ready
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with fixed-priority writes, optional zero register and
// write-to-read bypass, a busy-bit scoreboard and a post-reset clearing sequence.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave rf_io
);
  localparam int unsigned       Depth    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(Depth - 1);

  typedef enum logic {StInit, StRun} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              ready_q;
  logic [DATA_W-1:0] mem_q [Depth];
  logic [Depth-1:0]  busy_q, busy_d;

  logic [ADDR_W-1:0] wr_addr [NUM_WR];
  logic [DATA_W-1:0] wr_data [NUM_WR];
  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  logic              run;

  for (genvar i = 0; i < NUM_WR; i++) begin : g_wr_unpack
    assign wr_addr[i] = rf_io.wr_addr[i*ADDR_W +: ADDR_W];
    assign wr_data[i] = rf_io.wr_data[i*DATA_W +: DATA_W];
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_unpack
    assign rd_addr[k] = rf_io.rd_addr[k*ADDR_W +: ADDR_W];
  end

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Issue is applied after write clears so a same-edge issue leaves the entry busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (rf_io.wr_en[i]) busy_d[wr_addr[i]] = 1'b0;
    end
    if (rf_io.issue_en && !is_zero(rf_io.issue_addr)) busy_d[rf_io.issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInit;
      clr_cnt_q <= '0;
      busy_q    <= '0;
      ready_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          mem_q[clr_cnt_q] <= '0;
          clr_cnt_q        <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == LastAddr) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        StRun: begin
          // Ascending loop: the highest-indexed port's assignment lands last and wins.
          for (int i = 0; i < NUM_WR; i++) begin
            if (rf_io.wr_en[i] && !is_zero(wr_addr[i])) mem_q[wr_addr[i]] <= wr_data[i];
          end
          busy_q <= busy_d;
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign run         = !rst && (state_q == StRun);
  assign rf_io.ready = ready_q;

  always_comb begin
    rf_io.rd_data = '0;
    rf_io.rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (run && rf_io.rd_en[k] && !is_zero(rd_addr[k])) begin
        rf_io.rd_data[k*DATA_W +: DATA_W] = mem_q[rd_addr[k]];
        rf_io.rd_busy[k]                  = busy_q[rd_addr[k]];
        if (BYPASS) begin
          for (int i = 0; i < NUM_WR; i++) begin
            if (rf_io.wr_en[i] && (wr_addr[i] == rd_addr[k])) begin
              rf_io.rd_data[k*DATA_W +: DATA_W] = wr_data[i];
              rf_io.rd_busy[k]                  = 1'b0;
            end
          end
        end
      end
    end
  end
endmodule
